// File: rtl/next_pc_unit.sv
// next_pc_unit: program-counter register and next-PC selection for the
// single-cycle MIPS datapath, with a small BOOT/RUN/HALT/FAULT control FSM
// for stall, halt/resume and misaligned-target handling.
// Optional build macro: PERF_CNT_EN adds instr_cnt and br_taken_cnt.
module next_pc_unit #(
   parameter int             N            = 32,
   parameter logic [N-1:0]   RESET_VECTOR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          branch,
   input  logic          zero,
   input  logic          jump,
   input  logic [N-1:0]  shift_imm,
   input  logic [25:0]   instr_index,
   input  logic          halt_req,
   input  logic          resume,
   output logic [N-1:0]  pc,
   output logic [N-1:0]  pc_plus4,
   output logic [N-1:0]  pc_branch,
   output logic          fetch_valid,
   output logic          fault,
   output logic [N-1:0]  fault_pc,
   output logic [1:0]    state
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]   instr_cnt,
   output logic [31:0]   br_taken_cnt
`endif
);

   typedef enum logic [1:0] {
      BOOT  = 2'b00,
      RUN   = 2'b01,
      HALT  = 2'b10,
      FAULT = 2'b11
   } state_t;

   localparam logic [N-1:0] PC_INC = N'(3'd4);

   // A target is legal only when it lands on a word boundary.
   function automatic logic is_word_aligned(input logic [N-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

   state_t        state_r;
   state_t        state_n_s;
   logic [N-1:0]  pc_r;
   logic [N-1:0]  pc_n_s;
   logic          fetch_valid_r;
   logic          fault_r;
   logic          fault_n_s;
   logic [N-1:0]  fault_pc_r;
   logic [N-1:0]  fault_pc_n_s;
   logic [N-1:0]  pc_plus4_s;
   logic [N-1:0]  pc_branch_s;
   logic [N-1:0]  jump_target_s;
   logic [N-1:0]  target_s;
   logic          br_sel_s;
   logic          advance_s;

   assign pc_plus4_s  = pc_r + PC_INC;
   assign pc_branch_s = pc_plus4_s + shift_imm;

   // The jump keeps the region bits of pc_plus4 above bit 27 when they exist.
   generate
      if (N > 28) begin : g_jt_region
         assign jump_target_s = {pc_plus4_s[N-1:28], instr_index, 2'b00};
      end else begin : g_jt_flat
         assign jump_target_s = {instr_index, 2'b00};
      end
   endgenerate

   // Target selection: jump beats a taken branch, which beats sequential flow.
   always_comb begin
      target_s = pc_plus4_s;
      br_sel_s = 1'b0;
      if (jump) begin
         target_s = jump_target_s;
      end else if (branch && zero) begin
         target_s = pc_branch_s;
         br_sel_s = 1'b1;
      end else begin
         target_s = pc_plus4_s;
      end
   end

   // Control FSM next-state, next-PC and fault capture.
   always_comb begin
      state_n_s    = state_r;
      pc_n_s       = pc_r;
      fault_n_s    = fault_r;
      fault_pc_n_s = fault_pc_r;
      advance_s    = 1'b0;
      case (state_r)
         BOOT: begin
            state_n_s = RUN;
         end
         RUN: begin
            if (halt_req) begin
               state_n_s = HALT;
            end else if (stall) begin
               state_n_s = RUN;
            end else if (!is_word_aligned(target_s)) begin
               state_n_s    = FAULT;
               fault_n_s    = 1'b1;
               fault_pc_n_s = target_s;
            end else begin
               pc_n_s    = target_s;
               advance_s = 1'b1;
            end
         end
         HALT: begin
            if (resume) begin
               state_n_s = RUN;
            end else begin
               state_n_s = HALT;
            end
         end
         FAULT: begin
            state_n_s = FAULT;
         end
         default: begin
            state_n_s = BOOT;
         end
      endcase
   end

   // State, PC and fault registers; fetch_valid tracks the next state so it
   // rises on the same edge the FSM enters RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= BOOT;
         pc_r          <= RESET_VECTOR;
         fetch_valid_r <= 1'b0;
         fault_r       <= 1'b0;
         fault_pc_r    <= '0;
      end else begin
         state_r       <= state_n_s;
         pc_r          <= pc_n_s;
         fetch_valid_r <= (state_n_s == RUN);
         fault_r       <= fault_n_s;
         fault_pc_r    <= fault_pc_n_s;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] instr_cnt_r;
   logic [31:0] br_taken_cnt_r;

   // Count retired PC advances and the subset that took a branch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_cnt_r    <= 32'd0;
         br_taken_cnt_r <= 32'd0;
      end else begin
         if (advance_s) begin
            instr_cnt_r <= instr_cnt_r + 32'd1;
         end else begin
            instr_cnt_r <= instr_cnt_r;
         end
         if (advance_s && br_sel_s) begin
            br_taken_cnt_r <= br_taken_cnt_r + 32'd1;
         end else begin
            br_taken_cnt_r <= br_taken_cnt_r;
         end
      end
   end

   assign instr_cnt    = instr_cnt_r;
   assign br_taken_cnt = br_taken_cnt_r;
`endif

   assign pc          = pc_r;
   assign pc_plus4    = pc_plus4_s;
   assign pc_branch   = pc_branch_s;
   assign fetch_valid = fetch_valid_r;
   assign fault       = fault_r;
   assign fault_pc    = fault_pc_r;
   assign state       = state_r;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: table-driven bench for next_pc_unit. Each record drives one
// clock of inputs; the expected outputs go into a scoreboard queue and are
// compared one time unit after the following rising edge.
module tb_next_pc_unit;

   localparam logic [1:0] S_BOOT  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_HALT  = 2'b10;
   localparam logic [1:0] S_FAULT = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, branch, zero, jump, halt_req, resume;
   logic [31:0] shift_imm;
   logic [25:0] instr_index;
   logic [31:0] pc, pc_plus4, pc_branch, fault_pc;
   logic        fetch_valid, fault;
   logic [1:0]  state;
`ifdef PERF_CNT_EN
   logic [31:0] instr_cnt, br_taken_cnt;
`endif

   next_pc_unit #(.N(32), .RESET_VECTOR(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero),
      .jump(jump), .shift_imm(shift_imm), .instr_index(instr_index),
      .halt_req(halt_req), .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
      .pc_branch(pc_branch), .fetch_valid(fetch_valid), .fault(fault),
      .fault_pc(fault_pc), .state(state)
`ifdef PERF_CNT_EN
      , .instr_cnt(instr_cnt), .br_taken_cnt(br_taken_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst_n, stall, branch, zero, jump, halt_req, resume;
      logic [31:0] shift_imm;
      logic [25:0] instr_index;
      logic [31:0] exp_pc;
      logic [1:0]  exp_state;
      logic        exp_fv, exp_fault;
      logic [31:0] exp_fault_pc;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] pc, pc_plus4, pc_branch, fault_pc;
      logic [1:0]  state;
      logic        fv, fault;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(string nm, logic r, logic st, logic br, logic z,
                               logic j, logic h, logic rs, logic [31:0] si,
                               logic [25:0] ii, logic [31:0] epc, logic [1:0] es,
                               logic efv, logic ef, logic [31:0] efpc);
      vec_t v;
      v.name = nm; v.rst_n = r; v.stall = st; v.branch = br; v.zero = z;
      v.jump = j; v.halt_req = h; v.resume = rs; v.shift_imm = si;
      v.instr_index = ii; v.exp_pc = epc; v.exp_state = es; v.exp_fv = efv;
      v.exp_fault = ef; v.exp_fault_pc = efpc;
      return v;
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, req);
      end
   endtask

   // Drive one record, queue its expectation, then compare after the edge.
   task automatic step(vec_t v);
      exp_t e;
      rst_n = v.rst_n; stall = v.stall; branch = v.branch; zero = v.zero;
      jump = v.jump; halt_req = v.halt_req; resume = v.resume;
      shift_imm = v.shift_imm; instr_index = v.instr_index;
      e.name      = v.name;
      e.pc        = v.exp_pc;
      e.pc_plus4  = v.exp_pc + 32'd4;
      e.pc_branch = v.exp_pc + 32'd4 + v.shift_imm;
      e.fault_pc  = v.exp_fault_pc;
      e.state     = v.exp_state;
      e.fv        = v.exp_fv;
      e.fault     = v.exp_fault;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue expected one entry");
      end else begin
         e = sb.pop_front();
         check({e.name, ".pc"},          pc,                  e.pc);
         check({e.name, ".state"},       {30'd0, state},      {30'd0, e.state});
         check({e.name, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e.fv});
         check({e.name, ".fault"},       {31'd0, fault},      {31'd0, e.fault});
         check({e.name, ".fault_pc"},    fault_pc,            e.fault_pc);
         check({e.name, ".pc_plus4"},    pc_plus4,            e.pc_plus4);
         check({e.name, ".pc_branch"},   pc_branch,           e.pc_branch);
      end
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
      halt_req = 1'b0; resume = 1'b0; shift_imm = 32'd0; instr_index = 26'd0;

      //                name          rst st br z  j  h  rs shift_imm      instr_index   exp_pc         state    fv fl fault_pc
      vecs.push_back(mk("rst0",       0, 0, 0, 0, 0, 0, 0, 32'h0,         26'h0,        32'h0000_0000, S_BOOT,  0, 0, 32'h0));
      vecs.push_back(mk("rst1",       0, 0, 0, 0, 0, 0, 0, 32'h0,         26'h0,        32'h0000_0000, S_BOOT,  0, 0, 32'h0));
      vecs.push_back(mk("boot",       1, 0, 0, 0, 0, 1, 0, 32'h0,         26'h0,        32'h0000_0000, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("seq4",       1, 0, 0, 0, 0, 0, 0, 32'h0,         26'h0,        32'h0000_0004, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("seq8",       1, 0, 0, 0, 0, 0, 0, 32'h0,         26'h0,        32'h0000_0008, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("jmp10",      1, 0, 0, 0, 1, 0, 0, 32'h0,         26'h4,        32'h0000_0010, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("stall",      1, 1, 1, 1, 0, 0, 0, 32'h20,        26'h0,        32'h0000_0010, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("br_taken",   1, 0, 1, 1, 0, 0, 0, 32'h20,        26'h0,        32'h0000_0034, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("br_not",     1, 0, 1, 0, 0, 0, 0, 32'h20,        26'h0,        32'h0000_0038, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("jmp20",      1, 0, 0, 0, 1, 0, 0, 32'h0,         26'h8,        32'h0000_0020, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("halt_stall", 1, 1, 0, 0, 0, 1, 0, 32'h0,         26'h0,        32'h0000_0020, S_HALT,  0, 0, 32'h0));
      vecs.push_back(mk("halt_hold",  1, 0, 0, 0, 1, 1, 0, 32'h0,         26'h100,      32'h0000_0020, S_HALT,  0, 0, 32'h0));
      vecs.push_back(mk("resume",     1, 0, 0, 0, 0, 0, 1, 32'h0,         26'h0,        32'h0000_0020, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("post_res",   1, 0, 0, 0, 0, 0, 0, 32'h0,         26'h0,        32'h0000_0024, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("br_far",     1, 0, 1, 1, 0, 0, 0, 32'h0FFF_FFE0, 26'h0,        32'h1000_0008, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("jmp_over",   1, 0, 1, 1, 1, 0, 0, 32'h20,        26'h40,       32'h1000_0100, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("br_top",     1, 0, 1, 1, 0, 0, 0, 32'hEFFF_FEF8, 26'h0,        32'hFFFF_FFFC, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("wrap",       1, 0, 0, 0, 0, 0, 0, 32'h0,         26'h0,        32'h0000_0000, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("jmp40",      1, 0, 0, 0, 1, 0, 0, 32'h0,         26'h10,       32'h0000_0040, S_RUN,   1, 0, 32'h0));
      vecs.push_back(mk("misalign",   1, 0, 1, 1, 0, 0, 0, 32'h2,         26'h0,        32'h0000_0040, S_FAULT, 0, 1, 32'h46));
      vecs.push_back(mk("flt_resume", 1, 0, 0, 0, 0, 0, 1, 32'h0,         26'h0,        32'h0000_0040, S_FAULT, 0, 1, 32'h46));
      vecs.push_back(mk("flt_ctrl",   1, 0, 0, 0, 1, 1, 0, 32'h0,         26'h3,        32'h0000_0040, S_FAULT, 0, 1, 32'h46));
      vecs.push_back(mk("flt_rst",    0, 0, 0, 0, 0, 0, 1, 32'h0,         26'h0,        32'h0000_0000, S_BOOT,  0, 0, 32'h0));

      foreach (vecs[i]) step(vecs[i]);

      // Halt takes priority over a misaligned branch; reset then wins mid-HALT.
      step(mk("h_boot",  1, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, S_RUN,  1, 0, 32'h0));
      step(mk("h_mis",   1, 0, 1, 1, 0, 1, 0, 32'h2, 26'h0, 32'h0, S_HALT, 0, 0, 32'h0));
      step(mk("h_rst",   0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0, S_BOOT, 0, 0, 32'h0));

      // Counter run: 3 sequential, 1 taken branch, 1 jump, 2 stalls.
      step(mk("p_boot",  1, 0, 0, 0, 0, 0, 0, 32'h0,  26'h0,  32'h0000_0000, S_RUN, 1, 0, 32'h0));
      step(mk("p_seq1",  1, 0, 0, 0, 0, 0, 0, 32'h0,  26'h0,  32'h0000_0004, S_RUN, 1, 0, 32'h0));
      step(mk("p_seq2",  1, 0, 0, 0, 0, 0, 0, 32'h0,  26'h0,  32'h0000_0008, S_RUN, 1, 0, 32'h0));
      step(mk("p_seq3",  1, 0, 0, 0, 0, 0, 0, 32'h0,  26'h0,  32'h0000_000C, S_RUN, 1, 0, 32'h0));
      step(mk("p_stl1",  1, 1, 0, 0, 1, 0, 0, 32'h0,  26'h7,  32'h0000_000C, S_RUN, 1, 0, 32'h0));
      step(mk("p_br",    1, 0, 1, 1, 0, 0, 0, 32'h10, 26'h0,  32'h0000_0020, S_RUN, 1, 0, 32'h0));
      step(mk("p_stl2",  1, 1, 1, 1, 0, 0, 0, 32'h10, 26'h0,  32'h0000_0020, S_RUN, 1, 0, 32'h0));
      step(mk("p_jmp",   1, 0, 0, 0, 1, 0, 0, 32'h0,  26'h40, 32'h0000_0100, S_RUN, 1, 0, 32'h0));
`ifdef PERF_CNT_EN
      check("instr_cnt",    instr_cnt,    32'd5);
      check("br_taken_cnt", br_taken_cnt, 32'd1);
`endif

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Program-counter register and next-PC selection stage for the single-cycle MIPS datapath.
- Consumes the word-aligned, already-shifted branch offset from the shift-left-by-two stage and forms PC+4, the branch target and the jump target.
- Registers the selected PC each cycle.
- Adds stall, halt/resume and misaligned-target fault handling through a small control FSM.

Parameters:
- N, 32, datapath/PC width in bits (N ≥ 28 required; jump region uses pc_plus4[N-1:28] when N = 32).
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- stall  input  1  hold PC this cycle (RUN only).
- branch  input  1  branch instruction decoded.
- zero  input  1  ALU zero flag; branch taken = branch & zero.
- jump  input  1  jump instruction decoded.
- shift_imm  input  N  sign-extended immediate already shifted left by 2.
- instr_index  input  26  jump target field, instr[25:0].
- halt_req  input  1  request to enter HALT.
- resume  input  1  leave HALT.
- pc  output  N  current PC (registered).
- pc_plus4  output  N  pc + 4, combinational.
- pc_branch  output  N  pc_plus4 + shift_imm, combinational.
- fetch_valid  output  1  high when state == RUN (registered).
- fault  output  1  sticky misaligned-target flag.
- fault_pc  output  N  offending target address.
- state  output  2  BOOT=00, RUN=01, HALT=10, FAULT=11.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc = RESET_VECTOR, state = BOOT, fetch_valid = 0, fault = 0, fault_pc = 0.
  - Reset overrides every other input, in every state, including mid-HALT and mid-FAULT.
- Arithmetic:
  - pc_plus4 and pc_branch are modulo 2^N; no overflow flag. Example: pc = FFFF_FFFC gives pc_plus4 = 0000_0000.
  - Jump target = {pc_plus4[N-1:28], instr_index, 2'b00}.
- Next-PC priority: jump > (branch & zero) > pc_plus4. If jump and branch are both set, jump wins.
- BOOT:
  - Exactly one cycle; pc holds; fetch_valid = 0.
  - Next state is RUN unconditionally; halt_req in BOOT is ignored.
- RUN:
  - halt_req=1: state becomes HALT, pc holds. halt_req has priority over stall and over target selection.
  - Otherwise, stall=1: pc holds, state stays RUN.
  - Otherwise, selected target with target[1:0] != 2'b00:
    - pc holds, fault set to 1, fault_pc = target, state becomes FAULT.
  - Otherwise: pc = selected target.
- HALT:
  - pc holds; fetch_valid = 0.
  - resume=1: state becomes RUN; pc still unchanged on that edge.
  - halt_req is ignored while in HALT.
- FAULT:
  - pc, fault and fault_pc hold; fetch_valid = 0.
  - Only reset exits this state.
- Register timing: fetch_valid is registered alongside state, so it rises on the same edge state enters RUN.
- Latency: one clock from the control inputs to an updated pc. pc_plus4 and pc_branch follow pc combinationally in the same cycle.
- Control inputs have no effect outside RUN, except resume in HALT.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined, two extra outputs are added:
  - instr_cnt (32 bits): increments on every cycle pc advances in RUN.
  - br_taken_cnt (32 bits): increments when that advance selects the branch target.
  - Both clear on reset and wrap at 2^32.
  - Jumps count only in instr_cnt.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then 1; no control inputs asserted.
  - Response: pc = 0 in BOOT for 1 cycle; fetch_valid rises next edge; pc then steps 0 → 4 → 8.
- Taken branch with stall:
  - Stimulus: pc = 0x10, branch=1, zero=1, shift_imm = 0x20.
  - Response: pc = 0x34 next edge. Repeating with stall=1 keeps pc at 0x10.
- Jump over branch:
  - Stimulus: pc = 0x1000_0008, jump=1, branch=1, zero=1, instr_index = 0x000_0040.
  - Response: pc = 0x1000_0100.
- Misaligned fault:
  - Stimulus: pc = 0x40, branch=1, zero=1, shift_imm = 0x2.
  - Response: state = FAULT, fault = 1, fault_pc = 0x46, pc stays 0x40 despite resume; rst_n=0 clears everything.
- Halt/resume with simultaneous stall and wrap:
  - Stimulus: halt_req=1 and stall=1 together at pc = 0x20, then resume=1.
  - Response: HALT with pc = 0x20; resume returns to RUN with pc still 0x20, then 0x24.
  - Separately, pc = FFFF_FFFC advances to 0.
- PERF_CNT_EN build:
  - Stimulus: 3 sequential instructions, 1 taken branch, 1 jump, with 2 stall cycles interleaved.
  - Response: instr_cnt = 5, br_taken_cnt = 1.
